// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU: FSM states, operation codes, operand-A source codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_READY = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOT   = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6,
        OP_PASSB = 3'd7
    } op_t;

    // 11 is a second encoding of "persist" so every a_sel value is defined.
    typedef enum logic [1:0] {
        ASEL_PERSIST  = 2'b00,
        ASEL_LOAD     = 2'b01,
        ASEL_ZERO     = 2'b10,
        ASEL_PERSIST2 = 2'b11
    } asel_t;

endpackage

// File: rtl/seq_mult.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// Latency: done is high in the cycle before the WIDTH-th edge after start; product is valid then.
// Backpressure: none; abort cancels an operation in flight.
// Ports: clk, rst (sync active-low), start/a/b load a new operation, abort cancels,
//        done flags the final step, product is the full 2*WIDTH-bit result while done is high.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   addend;

    assign addend = mplier_q[0] ? mcand_q : '0;

    // The final partial sum is exposed combinationally so the consumer can
    // capture it on the same edge that retires the last step.
    assign product = prod_q + addend;
    assign done    = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            prod_q   <= '0;
        end else if (busy_q) begin
            prod_q   <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_alu_core.sv
// WIDTH-bit accumulator ALU with OFF/READY/RUN/ERROR control and a sequential multiplier.
// Latency: 1 edge after accept for logic/add/sub/pass, WIDTH edges for MUL.
// Backpressure: in_ready only in READY (registered); out_valid is a one-cycle pulse, never held.
// Ports: clk, rst (sync active-low), en (low forces OFF), in_valid/in_ready command handshake,
//        a_sel/op/operand_a/operand_b command fields, out_valid/result/carry/zero result side,
//        err/err_clear error state control, state exposes the FSM encoding.
module param_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit STICKY_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a_sel,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err,
    input  logic             err_clear,
    output logic [1:0]       state
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   a_q, b_q;
    op_t                op_q;

    logic               accept;
    logic               complete;
    logic [WIDTH-1:0]   a_src;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic [WIDTH:0]     sum, diff;
    logic               mul_start, mul_abort, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // en gates the accept so a command is never taken on the edge that powers down.
    assign accept = (state_q == ST_READY) && in_valid && en;

    always_comb begin
        a_src = acc_q;
        case (asel_t'(a_sel))
            ASEL_LOAD: a_src = operand_a;
            ASEL_ZERO: a_src = '0;
            default:   a_src = acc_q;
        endcase
    end

    // The multiplier loads straight from the command so its WIDTH steps line
    // up with the WIDTH RUN edges.
    assign mul_start = accept && (op_t'(op) == OP_MUL);
    assign mul_abort = !en;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (a_src),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Bit WIDTH of diff is the borrow because both operands are zero-extended.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_NOT:   alu_res = ~a_q;
            OP_ADD:   {alu_carry, alu_res} = sum;
            OP_SUB:   {alu_carry, alu_res} = diff;
            OP_MUL: begin
                alu_res   = mul_product[WIDTH-1:0];
                alu_carry = |mul_product[2*WIDTH-1:WIDTH];
            end
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    assign complete = (state_q == ST_RUN) && en && ((op_q != OP_MUL) || mul_done);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (!en) begin
            // Power-down beats everything, including err_clear and a finishing op.
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_READY;
                ST_READY: if (in_valid) state_d = ST_RUN;
                ST_RUN: begin
                    if (complete) begin
                        acc_d       = alu_res;
                        carry_d     = alu_carry;
                        out_valid_d = 1'b1;
                        state_d     = (alu_carry && STICKY_ERR) ? ST_ERROR : ST_READY;
                    end
                end
                ST_ERROR: if (err_clear) state_d = ST_READY;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_OFF;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                a_q  <= a_src;
                b_q  <= operand_b;
                op_q <= op_t'(op);
            end
        end
    end

    assign result    = acc_q;
    assign carry     = carry_q;
    assign zero      = (acc_q == '0);
    assign out_valid = out_valid_q;
    assign in_ready  = (state_q == ST_READY);
    assign err       = (state_q == ST_ERROR);
    assign state     = state_q;

endmodule

// File: tb/tb_param_alu_core.sv
// Directed bench for param_alu_core: a sticky and a non-sticky instance share all inputs.
// Latency: checks exact accept-to-out_valid distance per command.
// Backpressure: commands are only driven once in_ready is seen high.
module tb_param_alu_core;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [1:0] a_sel;
    logic [2:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       err_clear;

    logic       s1_in_ready, s1_out_valid, s1_carry, s1_zero, s1_err;
    logic [7:0] s1_result;
    logic [1:0] s1_state;
    logic       s0_in_ready, s0_out_valid, s0_carry, s0_zero, s0_err;
    logic [7:0] s0_result;
    logic [1:0] s0_state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
    } exp_t;
    exp_t exp_q[$];

    param_alu_core #(.WIDTH(8), .STICKY_ERR(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(s1_in_ready),
        .a_sel(a_sel), .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(s1_out_valid), .result(s1_result), .carry(s1_carry), .zero(s1_zero),
        .err(s1_err), .err_clear(err_clear), .state(s1_state)
    );

    param_alu_core #(.WIDTH(8), .STICKY_ERR(1'b0)) u_dut_ns (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(s0_in_ready),
        .a_sel(a_sel), .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(s0_out_valid), .result(s0_result), .carry(s0_carry), .zero(s0_zero),
        .err(s0_err), .err_clear(err_clear), .state(s0_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(s1_state), 32'd0);
        chk({tag, "_result"}, 32'(s1_result), 32'd0);
        chk({tag, "_carry"}, 32'(s1_carry), 32'd0);
        chk({tag, "_zero"}, 32'(s1_zero), 32'd1);
        chk({tag, "_out_valid"}, 32'(s1_out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(s1_in_ready), 32'd0);
        chk({tag, "_err"}, 32'(s1_err), 32'd0);
    endtask

    // Drive one command, push its expected outcome, then wait (bounded) for
    // out_valid and compare latency and popped expectation.
    task automatic issue(input string tag, input logic [1:0] s, input logic [2:0] o,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ec, input int lat);
        int   n;
        exp_t e;
        exp_q.push_back('{res: er, c: ec});
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(s1_in_ready), 32'd1);
        in_valid  = 1'b1;
        a_sel     = s;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (s1_out_valid) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, 32'(s1_result), 32'(e.res));
            chk({tag, "_carry"}, 32'(s1_carry), 32'(e.c));
            chk({tag, "_ns_result"}, 32'(s0_result), 32'(e.res));
        end
    endtask

    task automatic clear_err(input string tag);
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        chk({tag, "_state"}, 32'(s1_state), 32'd1);
        chk({tag, "_err"}, 32'(s1_err), 32'd0);
    endtask

    initial begin
        int ovs;
        clk = 1'b0; rst = 1'b0; en = 1'b0; in_valid = 1'b0; a_sel = 2'b00; op = 3'd0;
        operand_a = 8'd0; operand_b = 8'd0; err_clear = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        chk("en_ready_state", 32'(s1_state), 32'd1);
        chk("en_in_ready", 32'(s1_in_ready), 32'd1);

        // ADD 200+100 wraps to 44 with carry; sticky instance traps.
        issue("add_ovf", 2'b01, 3'd4, 8'd200, 8'd100, 8'd44, 1'b1, 1);
        chk("add_ovf_state", 32'(s1_state), 32'd3);
        chk("add_ovf_err", 32'(s1_err), 32'd1);
        chk("add_ovf_ns_state", 32'(s0_state), 32'd1);
        @(posedge clk);
        #1;
        chk("add_ovf_pulse", 32'(s1_out_valid), 32'd0);
        chk("add_ovf_hold_err", 32'(s1_state), 32'd3);
        clear_err("clr1");

        issue("mul_15x17", 2'b01, 3'd6, 8'd15, 8'd17, 8'd255, 1'b0, 8);
        issue("mul_acc_x2", 2'b00, 3'd6, 8'd0, 8'd2, 8'd254, 1'b1, 8);
        clear_err("clr2");

        issue("sub_borrow", 2'b01, 3'd5, 8'd5, 8'd7, 8'd254, 1'b1, 1);
        chk("sub_ns_state", 32'(s0_state), 32'd1);
        chk("sub_ns_err", 32'(s0_err), 32'd0);
        chk("sub_s_state", 32'(s1_state), 32'd3);
        clear_err("clr3");

        issue("or_zero", 2'b10, 3'd1, 8'd99, 8'd0, 8'd0, 1'b0, 1);
        chk("or_zero_flag", 32'(s1_zero), 32'd1);
        issue("add_3", 2'b00, 3'd4, 8'd99, 8'd3, 8'd3, 1'b0, 1);
        chk("add_3_zero", 32'(s1_zero), 32'd0);
        issue("not_a", 2'b00, 3'd3, 8'd0, 8'd0, 8'd252, 1'b0, 1);
        issue("and", 2'b01, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
        issue("xor", 2'b11, 3'd2, 8'h00, 8'hFF, 8'hCF, 1'b0, 1);
        issue("passb", 2'b00, 3'd7, 8'h00, 8'h5A, 8'h5A, 1'b0, 1);

        // MUL aborted by dropping en three cycles in.
        @(negedge clk);
        in_valid = 1'b1; a_sel = 2'b01; op = 3'd6; operand_a = 8'd3; operand_b = 8'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("abort_run_state", 32'(s1_state), 32'd2);
        chk("abort_run_in_ready", 32'(s1_in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_pre_no_ov", 32'(s1_out_valid), 32'd0);
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_state_off", 32'(s1_state), 32'd0);
        chk("abort_acc_kept", 32'(s1_result), 32'h5A);
        ovs = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (s1_out_valid || s0_out_valid) ovs++;
        end
        chk("abort_no_out_valid", 32'(ovs), 32'd0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("reenable_ready", 32'(s1_state), 32'd1);

        // err_clear together with en=0: OFF wins.
        issue("add_wrap", 2'b01, 3'd4, 8'd255, 8'd1, 8'd0, 1'b1, 1);
        chk("add_wrap_err", 32'(s1_state), 32'd3);
        @(negedge clk);
        en = 1'b0;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_vs_off_state", 32'(s1_state), 32'd0);
        chk("clr_vs_off_err", 32'(s1_err), 32'd0);
        @(negedge clk);
        en = 1'b1;
        err_clear = 1'b0;
        @(posedge clk);
        #1;
        chk("off_to_ready", 32'(s1_state), 32'd1);

        // Reset mid-MUL, with in_valid held (and ignored) during RUN.
        issue("passb_77", 2'b01, 3'd7, 8'd0, 8'h77, 8'h77, 1'b0, 1);
        @(negedge clk);
        in_valid = 1'b1; a_sel = 2'b01; op = 3'd6; operand_a = 8'd7; operand_b = 8'd9;
        @(posedge clk);
        #1;
        op = 3'd4;
        chk("rst_mid_run", 32'(s1_state), 32'd2);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("run_ignores_valid", 32'(s1_state), 32'd2);
            chk("run_acc_kept", 32'(s1_result), 32'h77);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(s1_state), 32'd1);
        issue("mul_after_rst", 2'b01, 3'd6, 8'd7, 8'd9, 8'd63, 1'b0, 8);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
